// File: rtl/spam_bus_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : spam_bus_ctl_if
// Brief    : SPAM core-port and peripheral-side signal bundle for spam_bus_ctl.
// Revision : 1.0 - initial release
// ============================================================================
interface spam_bus_ctl_if #(
    parameter int N_SLAVES = 4,
    parameter int DID_W    = 4,
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 32
);
    logic                       m_valid;
    logic                       m_r_nw;
    logic [DID_W-1:0]           m_did;
    logic [ADDR_W-1:0]          m_addr;
    logic [DATA_W-1:0]          m_wdata;
    logic                       m_busy_b;
    logic                       m_rvalid;
    logic [DATA_W-1:0]          m_rdata;
    logic [N_SLAVES-1:0]        s_valid;
    logic                       s_r_nw;
    logic [ADDR_W-1:0]          s_addr;
    logic [DATA_W-1:0]          s_wdata;
    logic [N_SLAVES-1:0]        s_busy_b;
    logic [N_SLAVES*DATA_W-1:0] s_rdata;

    // master: the core and its peripherals; slave: the bus controller between them
    modport master (
        output m_valid, m_r_nw, m_did, m_addr, m_wdata, s_busy_b, s_rdata,
        input  m_busy_b, m_rvalid, m_rdata, s_valid, s_r_nw, s_addr, s_wdata
    );
    modport slave (
        input  m_valid, m_r_nw, m_did, m_addr, m_wdata, s_busy_b, s_rdata,
        output m_busy_b, m_rvalid, m_rdata, s_valid, s_r_nw, s_addr, s_wdata
    );
endinterface
`default_nettype wire

// File: rtl/spam_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : spam_bus_ctl
// Brief    : Single-master SPAM sequencer with one-hot slave decode, timeout
//            and decode-error recovery. Define SPAM_BUSCTL_STATS_EN to add
//            transfer/timeout statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module spam_bus_ctl #(
    parameter int               N_SLAVES    = 4,
    parameter int               DID_W       = 4,
    parameter int               ADDR_W      = 24,
    parameter int               DATA_W      = 32,
    parameter int               TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(32'hDEADDEAD)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    spam_bus_ctl_if.slave bus,
    output logic       err_timeout,
    output logic       err_decode,
    output logic       err_overrun,
    input  wire logic  err_clr
`ifdef SPAM_BUSCTL_STATS_EN
    ,
    output logic [31:0] stat_xfers,
    output logic [15:0] stat_timeouts
`endif
);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int c_SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ERR   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SEL_W-1:0]   r_sel;
    logic                 r_err_slot;
    logic                 r_busy_b;
    logic                 r_rvalid;
    logic [DATA_W-1:0]    r_rdata;
    logic [N_SLAVES-1:0]  r_s_valid;
    logic                 r_r_nw;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_err_timeout;
    logic                 r_err_decode;
    logic                 r_err_overrun;

    logic [N_SLAVES-1:0]  w_onehot;
    logic [DATA_W-1:0]    w_slice [N_SLAVES];
    logic                 w_did_ok;
    logic                 w_sel_done;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic                 w_set_timeout;
    logic                 w_set_decode;
    logic                 w_set_overrun;

    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slave
        assign w_onehot[gi] = (bus.m_did == DID_W'(gi));
        assign w_slice[gi]  = bus.s_rdata[gi*DATA_W +: DATA_W];
    end

    assign w_did_ok      = (32'(bus.m_did) < 32'(N_SLAVES));
    assign w_sel_done    = bus.s_busy_b[r_sel];
    assign w_sel_rdata   = w_slice[r_sel];
    assign w_set_timeout = (r_state == S_WAIT) && !w_sel_done && (r_cnt == c_CNT_LAST);
    assign w_set_decode  = (r_state == S_ERR) && r_err_slot;
    assign w_set_overrun = bus.m_valid && (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_err_slot <= 1'b0;
            r_busy_b   <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_s_valid  <= '0;
            r_r_nw     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_rvalid  <= 1'b0;
            r_s_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.m_valid) begin
                        r_r_nw     <= bus.m_r_nw;
                        r_addr     <= bus.m_addr;
                        r_wdata    <= bus.m_wdata;
                        r_sel      <= bus.m_did[c_SEL_W-1:0];
                        r_busy_b   <= 1'b0;
                        r_err_slot <= 1'b0;
                        if (w_did_ok) begin
                            r_s_valid <= w_onehot;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_state   <= S_ERR;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // completion is tested first so it wins over a coincident timeout
                    if (w_sel_done) begin
                        r_rdata  <= w_sel_rdata;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (w_set_timeout) begin
                        r_rdata  <= ERR_DATA;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ERR: begin
                    // extra slot keeps decode-error latency equal to the fastest slave
                    if (r_err_slot) begin
                        r_rdata  <= ERR_DATA;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_err_slot <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_busy_b <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy_b <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_timeout <= 1'b0;
            r_err_decode  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_set_timeout)      r_err_timeout <= 1'b1;
            else if (err_clr)       r_err_timeout <= 1'b0;
            if (w_set_decode)       r_err_decode  <= 1'b1;
            else if (err_clr)       r_err_decode  <= 1'b0;
            if (w_set_overrun)      r_err_overrun <= 1'b1;
            else if (err_clr)       r_err_overrun <= 1'b0;
        end
    end

`ifdef SPAM_BUSCTL_STATS_EN
    logic [31:0] r_stat_xfers;
    logic [15:0] r_stat_timeouts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_xfers    <= '0;
            r_stat_timeouts <= '0;
        end else begin
            if (err_clr)
                r_stat_xfers <= r_rvalid ? 32'd1 : 32'd0;
            else if (r_rvalid)
                r_stat_xfers <= r_stat_xfers + 32'd1;
            if (err_clr)
                r_stat_timeouts <= w_set_timeout ? 16'd1 : 16'd0;
            else if (w_set_timeout && (r_stat_timeouts != 16'hFFFF))
                r_stat_timeouts <= r_stat_timeouts + 16'd1;
        end
    end

    assign stat_xfers    = r_stat_xfers;
    assign stat_timeouts = r_stat_timeouts;
`endif

    assign bus.m_busy_b = r_busy_b;
    assign bus.m_rvalid = r_rvalid;
    assign bus.m_rdata  = r_rdata;
    assign bus.s_valid  = r_s_valid;
    assign bus.s_r_nw   = r_r_nw;
    assign bus.s_addr   = r_addr;
    assign bus.s_wdata  = r_wdata;
    assign err_timeout  = r_err_timeout;
    assign err_decode   = r_err_decode;
    assign err_overrun  = r_err_overrun;
endmodule
`default_nettype wire

// File: tb/tb_spam_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spam_bus_ctl
// Brief    : Randomized self-checking bench for spam_bus_ctl against a
//            cycle-indexed expectation timeline built from transaction rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spam_bus_ctl;
    localparam int          c_NS   = 4;
    localparam int          c_T    = 8;
    localparam int          c_NCYC = 4096;
    localparam logic [31:0] c_ERR  = 32'hDEADDEAD;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic err_clr = 1'b0;
    logic err_timeout, err_decode, err_overrun;
`ifdef SPAM_BUSCTL_STATS_EN
    logic [31:0] stat_xfers;
    logic [15:0] stat_timeouts;
`endif

    spam_bus_ctl_if #(.N_SLAVES(c_NS), .DID_W(4), .ADDR_W(24), .DATA_W(32)) bus ();

    spam_bus_ctl #(
        .N_SLAVES(c_NS), .DID_W(4), .ADDR_W(24), .DATA_W(32),
        .TIMEOUT_CYC(c_T), .ERR_DATA(c_ERR)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .err_timeout(err_timeout), .err_decode(err_decode),
        .err_overrun(err_overrun), .err_clr(err_clr)
`ifdef SPAM_BUSCTL_STATS_EN
        , .stat_xfers(stat_xfers), .stat_timeouts(stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    // expected outputs per cycle index
    bit          exp_busy [c_NCYC];
    bit          exp_rv   [c_NCYC];
    logic [3:0]  exp_sv   [c_NCYC];
    logic [31:0] exp_rd   [c_NCYC];
    logic [2:0]  exp_err  [c_NCYC];   // {overrun, decode, timeout}
    bit          exp_rnw  [c_NCYC];
    logic [23:0] exp_addr [c_NCYC];
    logic [31:0] exp_wd   [c_NCYC];

    int cyc = 0, checks = 0, errors = 0;
    int rv_cnt = 0, last_rv_cyc = 0, sv_cnt = 0, sv_last_cyc = 0, lo_cnt = 0;
    logic [31:0] last_rd = '0;
    logic [3:0]  sv_last_val = '0;
    logic [3:0]  sel_mask = '0;
    int          done_cyc = -1, done_sel = 0;
    logic [31:0] done_dat = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic void reset_from(input int from);
        for (int c = from; c < c_NCYC; c++) begin
            exp_busy[c] = 1'b1; exp_rv[c] = 1'b0; exp_sv[c] = '0; exp_rd[c] = '0;
            exp_err[c] = '0; exp_rnw[c] = 1'b0; exp_addr[c] = '0; exp_wd[c] = '0;
        end
    endfunction

    function automatic void set_rd(input int from, input logic [31:0] v);
        for (int c = from; c < c_NCYC; c++) exp_rd[c] = v;
    endfunction

    function automatic void set_flag(input int from, input int b);
        for (int c = from; c < c_NCYC; c++) exp_err[c][b] = 1'b1;
    endfunction

    function automatic void clr_flags(input int from);
        for (int c = from; c < c_NCYC; c++) exp_err[c] = '0;
    endfunction

    function automatic void set_sfields(input int from, input bit rnw, input logic [23:0] a,
                                        input logic [31:0] wd);
        for (int c = from; c < c_NCYC; c++) begin
            exp_rnw[c] = rnw; exp_addr[c] = a; exp_wd[c] = wd;
        end
    endfunction

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (cyc >= 2 && cyc < c_NCYC) begin
                chk("m_busy_b", 32'(bus.m_busy_b), 32'(exp_busy[cyc]));
                chk("m_rvalid", 32'(bus.m_rvalid), 32'(exp_rv[cyc]));
                chk("m_rdata",  bus.m_rdata, exp_rd[cyc]);
                chk("s_valid",  32'(bus.s_valid), 32'(exp_sv[cyc]));
                chk("s_r_nw",   32'(bus.s_r_nw), 32'(exp_rnw[cyc]));
                chk("s_addr",   32'(bus.s_addr), 32'(exp_addr[cyc]));
                chk("s_wdata",  bus.s_wdata, exp_wd[cyc]);
                chk("err_flags", 32'({err_overrun, err_decode, err_timeout}), 32'(exp_err[cyc]));
            end
            if (bus.m_rvalid === 1'b1) begin
                rv_cnt++; last_rv_cyc = cyc; last_rd = bus.m_rdata;
            end
            if (bus.s_valid !== 4'b0000) begin
                sv_cnt++; sv_last_cyc = cyc; sv_last_val = bus.s_valid;
            end
            if (bus.m_busy_b === 1'b0) lo_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        bus.m_valid  = 1'b0;
        err_clr      = 1'b0;
        bus.s_busy_b = 4'($urandom) & ~sel_mask;
        bus.s_rdata  = {$urandom, $urandom, $urandom, $urandom};
        if (cyc == done_cyc) begin
            bus.s_busy_b = bus.s_busy_b | sel_mask;
            bus.s_rdata[done_sel*32 +: 32] = done_dat;
        end
    endtask

    task automatic request(input logic [3:0] did, input bit rnw, input logic [23:0] a,
                           input logic [31:0] wd);
        bus.m_valid = 1'b1; bus.m_did = did; bus.m_r_nw = rnw;
        bus.m_addr = a; bus.m_wdata = wd;
    endtask

    task automatic idle_clr();
        err_clr = 1'b1;
        clr_flags(cyc + 1);
        tick();
    endtask

    // k: cycle (relative to request) at which the slave reports done; 0 = never
    // ovr: cycle of an extra m_valid while busy (0 none, -1 random); clr: err_clr with it
    task automatic run_txn(input logic [3:0] did, input bit rnw, input logic [23:0] a,
                           input logic [31:0] wd, input int k, input logic [31:0] dat,
                           input int ovr, input bit clr);
        int t0, tr, o, fb, oc;
        bit bad, to;
        t0  = cyc;
        bad = (did >= 4'(c_NS));
        to  = !bad && (k == 0 || k > c_T + 1);
        tr  = bad ? t0 + 3 : (to ? t0 + c_T + 2 : t0 + k + 1);
        o   = (ovr < 0) ? int'($urandom_range(tr - t0, 1)) : ovr;
        request(did, rnw, a, wd);
        sel_mask = bad ? 4'b0000 : (4'b0001 << did);
        done_sel = int'(did[1:0]);
        done_cyc = (bad || k == 0) ? -1 : t0 + k;
        done_dat = dat;
        for (int c = t0 + 1; c <= tr; c++) exp_busy[c] = 1'b0;
        exp_rv[tr] = 1'b1;
        if (!bad) exp_sv[t0 + 1] = 4'b0001 << did;
        set_sfields(t0 + 1, rnw, a, wd);
        set_rd(tr, (bad || to) ? c_ERR : dat);
        fb = bad ? 1 : (to ? 0 : -1);
        oc = t0 + o + 1;
        if (o > 0 && clr && oc > tr) begin
            if (fb >= 0) set_flag(tr, fb);
            clr_flags(oc);
        end else begin
            if (o > 0 && clr) clr_flags(oc);
            if (fb >= 0) set_flag(tr, fb);
        end
        if (o > 0) set_flag(oc, 2);
        while (cyc <= tr) begin
            tick();
            if (o > 0 && cyc == t0 + o) begin
                request(4'($urandom), 1'($urandom), 24'($urandom), $urandom);
                err_clr = clr;
            end
        end
        sel_mask = '0;
        done_cyc = -1;
    endtask

    initial begin
        int t0, rvb, svb, lob;
        logic [3:0] did;
        logic [31:0] dat;
        reset_from(0);
        bus.m_valid = 1'b0; bus.m_r_nw = 1'b0; bus.m_did = '0; bus.m_addr = '0;
        bus.m_wdata = '0; bus.s_busy_b = '0; bus.s_rdata = '0;
        fork
            compare_loop();
        join_none
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset m_busy_b", 32'(bus.m_busy_b), 32'd1);
        chk("reset m_rdata", bus.m_rdata, 32'h0);
        chk("reset s_valid", 32'(bus.s_valid), 32'h0);

        // read did=1, slave done at relative cycle 4
        t0 = cyc; rvb = rv_cnt;
        run_txn(4'd1, 1'b1, 24'h000010, 32'h0, 4, 32'h12345678, 0, 1'b0);
        chk("t1 rvalid count", 32'(rv_cnt - rvb), 32'd1);
        chk("t1 rvalid cycle", 32'(last_rv_cyc - t0), 32'd5);
        chk("t1 rdata", last_rd, 32'h12345678);
        chk("t1 s_valid cycle", 32'(sv_last_cyc - t0), 32'd1);
        chk("t1 s_valid", 32'(sv_last_val), 32'b0010);
        chk("t1 err flags", 32'({err_overrun, err_decode, err_timeout}), 32'd0);

        // write did=0, done at cycle 2
        t0 = cyc; lob = lo_cnt;
        run_txn(4'd0, 1'b0, 24'h000123, 32'hA5A5A5A5, 2, 32'h0BADF00D, 0, 1'b0);
        chk("t2 rvalid cycle", 32'(last_rv_cyc - t0), 32'd3);
        chk("t2 busy low cycles", 32'(lo_cnt - lob), 32'd3);
        chk("t2 s_wdata", bus.s_wdata, 32'hA5A5A5A5);
        chk("t2 s_r_nw", 32'(bus.s_r_nw), 32'd0);

        // timeout on did=2
        t0 = cyc; rvb = rv_cnt;
        run_txn(4'd2, 1'b1, 24'h000040, 32'h0, 0, 32'h0, 0, 1'b0);
        chk("t3 rvalid count", 32'(rv_cnt - rvb), 32'd1);
        chk("t3 rvalid cycle", 32'(last_rv_cyc - t0), 32'(c_T + 2));
        chk("t3 rdata", last_rd, c_ERR);
        chk("t3 err_timeout", 32'(err_timeout), 32'd1);
        idle_clr();
        chk("t3 err_timeout cleared", 32'(err_timeout), 32'd0);

        // completion on the same cycle as the timeout limit
        t0 = cyc;
        run_txn(4'd2, 1'b1, 24'h000044, 32'h0, c_T + 1, 32'h600DD00D, 0, 1'b0);
        chk("tb rdata", last_rd, 32'h600DD00D);
        chk("tb err_timeout", 32'(err_timeout), 32'd0);

        // decode error
        t0 = cyc; svb = sv_cnt;
        run_txn(4'hF, 1'b1, 24'h000050, 32'h0, 2, 32'h0, 0, 1'b0);
        chk("t4 no s_valid", 32'(sv_cnt - svb), 32'd0);
        chk("t4 rvalid cycle", 32'(last_rv_cyc - t0), 32'd3);
        chk("t4 rdata", last_rd, c_ERR);
        chk("t4 err_decode", 32'(err_decode), 32'd1);

        // err_clr coinciding with an overrun: overrun stays, decode clears
        run_txn(4'd3, 1'b1, 24'h000060, 32'h0, 3, 32'h13579BDF, 2, 1'b1);
        chk("tw err_overrun", 32'(err_overrun), 32'd1);
        chk("tw err_decode", 32'(err_decode), 32'd0);
        idle_clr();

        // overrun during a pending read
        rvb = rv_cnt;
        run_txn(4'd1, 1'b1, 24'h000070, 32'h0, 4, 32'h2468ACE0, 2, 1'b0);
        chk("t5 rvalid count", 32'(rv_cnt - rvb), 32'd1);
        chk("t5 err_overrun", 32'(err_overrun), 32'd1);
`ifdef SPAM_BUSCTL_STATS_EN
        chk("t5 stat_xfers", stat_xfers, 32'd1);
`endif

        // reset while waiting, then a fresh read
        t0 = cyc; rvb = rv_cnt;
        request(4'd2, 1'b1, 24'h000080, 32'h0);
        sel_mask = 4'b0100;
        for (int c = t0 + 1; c <= t0 + 3; c++) exp_busy[c] = 1'b0;
        exp_sv[t0 + 1] = 4'b0100;
        set_sfields(t0 + 1, 1'b1, 24'h000080, 32'h0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        reset_from(cyc);
        tick();
        rst = 1'b0;
        sel_mask = '0;
        tick();
        t0 = cyc;
        run_txn(4'd3, 1'b1, 24'h000090, 32'h0, 2, 32'hCAFEBABE, 0, 1'b0);
        chk("t6 rvalid count", 32'(rv_cnt - rvb), 32'd1);
        chk("t6 rvalid cycle", 32'(last_rv_cyc - t0), 32'd3);
        chk("t6 rdata", last_rd, 32'hCAFEBABE);

        // randomized traffic
        for (int n = 0; n < 60 && cyc < c_NCYC - 40; n++) begin
            did = ($urandom_range(7, 0) == 0) ? 4'($urandom_range(15, 4)) : 4'($urandom_range(3, 0));
            dat = $urandom;
            run_txn(did, 1'($urandom), 24'($urandom), $urandom,
                    ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 2)),
                    dat, ($urandom_range(3, 0) == 0) ? -1 : 0, 1'($urandom));
            for (int g = int'($urandom_range(2, 0)); g > 0; g--) begin
                if ($urandom_range(5, 0) == 0) idle_clr();
                else tick();
            end
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
